dhash_ctrl: RTL and testbench
=============================

Name: dhash_ctrl

Overview:
Sequencer for the dHash difference-hash datapath. On a start request it fetches one downscaled ROWS x COLS greyscale thumbnail from the thumbnail RAM and streams it row-major to the hash datapath with row/col indices. It then waits for the datapath's valid pulse, captures the 64-bit hash and offers it downstream on a valid/ready handshake. It sits between the downscaler's thumbnail buffer and the hash-compare/search stage.

Parameters:
PIX_WIDTH, 8, pixel width in bits
ROWS, 8, thumbnail rows
COLS, 9, thumbnail columns (COLS-1 comparisons per row)
ADDR_WIDTH, 10, thumbnail RAM address width
HASH_WIDTH, 64, hash width; must equal ROWS*(COLS-1)
TIMEOUT, 15, maximum wait cycles for hash_vld after the last pixel

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset; 0 resets everything
start  in  1  request hash of the thumbnail at base_addr; sampled only in IDLE
base_addr  in  ADDR_WIDTH  address of pixel (0,0); sampled with start
busy  out  1  high in every state except IDLE
mem_rd_en  out  1  RAM read strobe
mem_addr  out  ADDR_WIDTH  RAM read address
mem_rd_data  in  PIX_WIDTH  RAM data; valid exactly 1 cycle after mem_rd_en
hash_clr  out  1  one-cycle clear of datapath shift register
hash_pix_vld  out  1  hash_pix/hash_row/hash_col valid
hash_pix  out  PIX_WIDTH  pixel to datapath
hash_row  out  4  row index 0..ROWS-1
hash_col  out  4  column index 0..COLS-1
hash_vld  in  1  datapath result valid pulse
hash_in  in  HASH_WIDTH  datapath result
out_valid  out  1  captured hash available
out_ready  in  1  downstream accept
out_hash  out  HASH_WIDTH  captured hash
err  out  1  one-cycle pulse on hash timeout
perf_cycles  out  16  see Optional Feature

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0.
- States: IDLE, CLEAR, FETCH, DRAIN, WAIT_HASH, OUTPUT.
- IDLE: start=1 -> latch base_addr, go CLEAR. start ignored in all other states.
- CLEAR: hash_clr=1 for exactly one cycle -> FETCH.
- FETCH: one read per cycle, mem_addr = base + r*COLS + c, c increments 0..COLS-1 then wraps to 0 with r+1; addition modulo 2^ADDR_WIDTH (wrap, no error). After read (ROWS-1, COLS-1) -> DRAIN. Exactly ROWS*COLS = 72 reads, no stalls.
- Pixel path: registered; read issued at cycle t -> hash_pix=mem_rd_data, hash_row/hash_col = indices of that read, hash_pix_vld=1 at cycle t+1. DRAIN presents the last pixel, then -> WAIT_HASH.
- WAIT_HASH: hash_vld=1 -> out_hash <= hash_in, go OUTPUT. hash_vld in the same cycle as the last pixel (DRAIN) is also captured. Timeout counter counts from entry; after TIMEOUT cycles without hash_vld -> err=1 for one cycle, out_hash unchanged, go IDLE.
- hash_vld outside WAIT_HASH/DRAIN: ignored.
- OUTPUT: out_valid=1, out_hash stable until out_valid && out_ready, then -> IDLE next cycle with out_valid=0. out_ready=1 on the first OUTPUT cycle is accepted.
- Latency (start to out_valid, zero-wait datapath responding in the DRAIN cycle): 1 (CLEAR) + 72 (FETCH) + 1 (DRAIN) + 1 = 75 cycles.
- Back-to-back: start asserted in the IDLE cycle following the handshake is accepted.
- rst low mid-operation: immediate return to IDLE, all outputs 0, no err.

Optional Feature:
DHASH_CTRL_PERF_EN defined: perf_cycles = saturating 16-bit count of cycles from start acceptance to the first out_valid cycle, cleared on start acceptance, held until the next start. Not defined: perf_cycles tied to 0 and the counter logic is absent.

Test Plan:
- RAM pixel(r,c)=r*9+c, base 0, datapath model pulses hash_vld in DRAIN with 0x0123456789ABCDEF -> 72 reads addr 0..71, hash_row/col scan (0,0)..(7,8), out_valid at cycle 75, out_hash=0x0123456789ABCDEF.
- base_addr=1020 (ADDR_WIDTH=10) -> addresses 1020..1023 then 0..67, no err.
- Datapath never pulses hash_vld -> err high exactly one cycle 15 cycles after WAIT_HASH entry, busy falls, out_valid stays 0.
- out_ready held 0 for 10 cycles, start pulsed during OUTPUT -> out_hash stable, start ignored; out_ready=1 -> IDLE next cycle.
- rst low during FETCH at read 30 -> all outputs 0 immediately; a fresh start yields a full 72-read sequence.
- DHASH_CTRL_PERF_EN defined, scenario 1 -> perf_cycles=75; undefined -> perf_cycles=0.

Source files
------------

// File: rtl/dhash_ctrl.sv
// dhash_ctrl - sequencer for the dHash difference-hash datapath.
//
// On start, it reads one ROWS x COLS greyscale thumbnail from the thumbnail
// RAM and streams it row-major to the hash datapath, tagging each pixel with
// its row and column. It then waits for the datapath result, captures the
// hash and offers it downstream on a valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   start_i            start request, sampled only in IDLE
//   base_addr_i        RAM address of pixel (0,0), sampled with start_i
//   busy_o             high in every state except IDLE
//   mem_rd_en_o        RAM read strobe
//   mem_addr_o         RAM read address
//   mem_rd_data_i      RAM data, valid one cycle after mem_rd_en_o
//   hash_clr_o         one-cycle clear of the datapath shift register
//   hash_pix_vld_o     hash_pix_o / hash_row_o / hash_col_o valid
//   hash_pix_o         pixel to the datapath
//   hash_row_o         row index of hash_pix_o
//   hash_col_o         column index of hash_pix_o
//   hash_vld_i         datapath result valid pulse
//   hash_in_i          datapath result
//   out_valid_o        captured hash available
//   out_ready_i        downstream accept
//   out_hash_o         captured hash
//   err_o              one-cycle pulse when the datapath result times out
//   perf_cycles_o      start-to-first-out_valid cycle count
//
// Build option DHASH_CTRL_PERF_EN: when defined, perf_cycles_o is a
// saturating count of cycles from start acceptance to the first out_valid
// cycle, held until the next start. When undefined it is tied to zero.
//
// State table:
//   state       | meaning
//   S_IDLE      | waiting for start
//   S_CLEAR     | hash_clr pulse to the datapath
//   S_FETCH     | one RAM read per cycle, ROWS*COLS reads
//   S_DRAIN     | last pixel presented, early hash_vld accepted
//   S_WAIT_HASH | waiting for hash_vld with timeout
//   S_OUTPUT    | out_valid held until out_ready

`timescale 1ns/1ps

module dhash_ctrl #(
  parameter int PIX_WIDTH  = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 9,
  parameter int ADDR_WIDTH = 10,
  parameter int HASH_WIDTH = 64,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  busy_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [PIX_WIDTH-1:0]  mem_rd_data_i,
  output logic                  hash_clr_o,
  output logic                  hash_pix_vld_o,
  output logic [PIX_WIDTH-1:0]  hash_pix_o,
  output logic [3:0]            hash_row_o,
  output logic [3:0]            hash_col_o,
  input  logic                  hash_vld_i,
  input  logic [HASH_WIDTH-1:0] hash_in_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [HASH_WIDTH-1:0] out_hash_o,
  output logic                  err_o,
  output logic [15:0]           perf_cycles_o
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_WAIT_HASH,
    S_OUTPUT
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            rd_row_q;
  logic [3:0]            rd_col_q;
  logic                  clr_q;
  logic                  pix_vld_q;
  logic [3:0]            pix_row_q;
  logic [3:0]            pix_col_q;
  logic                  out_valid_q;
  logic [HASH_WIDTH-1:0] out_hash_q;
  logic                  err_q;
  logic [TMR_W-1:0]      tmr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      clr_q       <= 1'b0;
      pix_vld_q   <= 1'b0;
      pix_row_q   <= '0;
      pix_col_q   <= '0;
      out_valid_q <= 1'b0;
      out_hash_q  <= '0;
      err_q       <= 1'b0;
      tmr_q       <= '0;
    end else begin
      clr_q     <= 1'b0;
      err_q     <= 1'b0;
      // The pixel tag trails the read by one cycle, lining up with the RAM data.
      pix_vld_q <= rd_en_q;
      pix_row_q <= rd_row_q;
      pix_col_q <= rd_col_q;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q  <= S_CLEAR;
            busy_q   <= 1'b1;
            clr_q    <= 1'b1;
            addr_q   <= base_addr_i;
            rd_row_q <= '0;
            rd_col_q <= '0;
          end
        end

        S_CLEAR: begin
          state_q <= S_FETCH;
          rd_en_q <= 1'b1;
        end

        S_FETCH: begin
          if (rd_row_q == LAST_ROW && rd_col_q == LAST_COL) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            // Row-major scan is contiguous, so base + r*COLS + c is a simple
            // increment; the address wraps modulo 2^ADDR_WIDTH.
            addr_q <= addr_q + 1'b1;
            if (rd_col_q == LAST_COL) begin
              rd_col_q <= '0;
              rd_row_q <= rd_row_q + 4'd1;
            end else begin
              rd_col_q <= rd_col_q + 4'd1;
            end
          end
        end

        S_DRAIN: begin
          tmr_q <= TMR_LOAD;
          if (hash_vld_i) begin
            state_q     <= S_OUTPUT;
            out_valid_q <= 1'b1;
            out_hash_q  <= hash_in_i;
          end else begin
            state_q <= S_WAIT_HASH;
          end
        end

        S_WAIT_HASH: begin
          if (hash_vld_i) begin
            state_q     <= S_OUTPUT;
            out_valid_q <= 1'b1;
            out_hash_q  <= hash_in_i;
          end else if (tmr_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end

        S_OUTPUT: begin
          if (out_ready_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign mem_rd_en_o    = rd_en_q;
  assign mem_addr_o     = addr_q;
  assign hash_clr_o     = clr_q;
  assign hash_pix_vld_o = pix_vld_q;
  // RAM output is already registered; gate it so idle cycles present zero.
  assign hash_pix_o     = pix_vld_q ? mem_rd_data_i : '0;
  assign hash_row_o     = pix_row_q;
  assign hash_col_o     = pix_col_q;
  assign out_valid_o    = out_valid_q;
  assign out_hash_o     = out_hash_q;
  assign err_o          = err_q;

`ifdef DHASH_CTRL_PERF_EN
  logic [15:0] perf_q;
  logic [15:0] perf_d;

  // The accepting cycle counts as cycle 1, so the value seen on the first
  // out_valid cycle equals the start-to-out_valid latency.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (start_i) begin
        perf_d = 16'd1;
      end
    end else if (state_q != S_OUTPUT && perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_dhash_ctrl.sv
`timescale 1ns/1ps

module tb_dhash_ctrl;

  localparam int PW      = 8;
  localparam int ROWS    = 8;
  localparam int COLS    = 9;
  localparam int AW      = 10;
  localparam int HW      = 64;
  localparam int TO      = 15;
  localparam int NPIX    = ROWS * COLS;
  localparam int K_DRAIN = NPIX + 2;
  localparam int NEVER   = 1000;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_OUT  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rd_data = '0;
  logic          hash_clr;
  logic          hash_pix_vld;
  logic [PW-1:0] hash_pix;
  logic [3:0]    hash_row;
  logic [3:0]    hash_col;
  logic          hash_vld = 1'b0;
  logic [HW-1:0] hash_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [HW-1:0] out_hash;
  logic          err;
  logic [15:0]   perf_cycles;

  always #5 clk = ~clk;

  dhash_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .base_addr_i   (base_addr),
    .busy_o        (busy),
    .mem_rd_en_o   (mem_rd_en),
    .mem_addr_o    (mem_addr),
    .mem_rd_data_i (mem_rd_data),
    .hash_clr_o    (hash_clr),
    .hash_pix_vld_o(hash_pix_vld),
    .hash_pix_o    (hash_pix),
    .hash_row_o    (hash_row),
    .hash_col_o    (hash_col),
    .hash_vld_i    (hash_vld),
    .hash_in_i     (hash_in),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_hash_o    (out_hash),
    .err_o         (err),
    .perf_cycles_o (perf_cycles)
  );

  // Thumbnail RAM: pixel at address a is a for a < 256, so base 0 gives r*9+c.
  logic [PW-1:0] ram [1024];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = PW'(i + (i >> 8) * 37);
  end
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase plus cycle offset k since start acceptance.
  // k=1 clear, k=2..73 reads, k=3..74 pixels, k=74 drain, 75..89 waiting.
  int            m_phase = P_IDLE;
  int            m_k = 0;
  int            m_perf = 0;
  logic [AW-1:0] m_base = '0;
  logic [HW-1:0] m_hash = '0;
  logic          m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE;
      m_k     <= 0;
      m_perf  <= 0;
      m_base  <= '0;
      m_hash  <= '0;
      m_err   <= 1'b0;
    end else begin
      m_err <= 1'b0;
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase <= P_RUN;
          m_k     <= 1;
          m_base  <= base_addr;
          m_perf  <= 1;
        end
        P_RUN: begin
          if (m_perf < 65535) m_perf <= m_perf + 1;
          if (m_k >= K_DRAIN && hash_vld) begin
            m_phase <= P_OUT;
            m_hash  <= hash_in;
          end else if (m_k == K_DRAIN + TO) begin
            m_phase <= P_IDLE;
            m_err   <= 1'b1;
          end else begin
            m_k <= m_k + 1;
          end
        end
        default: if (out_ready) m_phase <= P_IDLE;
      endcase
    end
  end

  // Cycle-by-cycle compare against the model.
  bit e_rd, e_vld;
  int idx;
  always @(negedge clk) begin
    e_rd  = (m_phase == P_RUN) && m_k >= 2 && m_k <= NPIX + 1;
    e_vld = (m_phase == P_RUN) && m_k >= 3 && m_k <= NPIX + 2;
    chk("busy", busy, m_phase != P_IDLE);
    chk("hash_clr", hash_clr, (m_phase == P_RUN) && m_k == 1);
    chk("mem_rd_en", mem_rd_en, e_rd);
    if (e_rd) chk("mem_addr", mem_addr, AW'(m_base + (m_k - 2)));
    chk("hash_pix_vld", hash_pix_vld, e_vld);
    if (e_vld) begin
      idx = m_k - 3;
      chk("hash_pix", hash_pix, ram[AW'(m_base + idx)]);
      chk("hash_row", hash_row, idx / COLS);
      chk("hash_col", hash_col, idx % COLS);
    end
    chk("out_valid", out_valid, m_phase == P_OUT);
    chk("out_hash", out_hash, m_hash);
    chk("err", err, m_err);
`ifdef DHASH_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, 16'(m_perf));
`else
    chk("perf_cycles", perf_cycles, 0);
`endif
  end

  // Stimulus state and per-transaction observations.
  int            d_resp;
  int            rdy_mode;
  logic [HW-1:0] h_txn;
  int            out_cycles;
  int            rd_cnt;
  int            r_lat;
  int            r_nerr;
  int            r_err_off;
  int            r_ov_cnt;
  int            addr_log [8];

  // Sets inputs for the current cycle; called at the falling edge.
  task automatic drive_cycle();
    hash_in = {$urandom, $urandom};
    if (m_phase == P_RUN && m_k == K_DRAIN + d_resp) begin
      hash_vld = 1'b1;
      hash_in  = h_txn;
    end else if (!(m_phase == P_RUN && m_k >= K_DRAIN)) begin
      hash_vld = ($urandom_range(7) == 0);
    end else begin
      hash_vld = 1'b0;
    end
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = $urandom_range(1) == 1;
      default: out_ready = (m_phase == P_OUT) && out_cycles >= 10;
    endcase
    if (m_phase == P_RUN) start = ($urandom_range(3) == 0);
    else if (m_phase == P_OUT) start = (rdy_mode == 2) ? 1'b1 : 1'b0;
    else start = 1'b0;
  endtask

  // Called at a falling edge with the model idle; returns at a falling edge
  // with the model idle again (or after a reset abort at cycle k=abort_k).
  task automatic run_txn(input logic [AW-1:0] b, input int d, input int mode,
                         input logic [HW-1:0] h, input int abort_k);
    int t0;
    int budget;
    bit done;
    d_resp = d; rdy_mode = mode; h_txn = h; out_cycles = 0;
    rd_cnt = 0; r_lat = -1; r_nerr = 0; r_err_off = -1; r_ov_cnt = 0;
    for (int i = 0; i < 8; i++) addr_log[i] = -1;
    start = 1'b1; base_addr = b; hash_vld = 1'b0; out_ready = 1'b0;
    t0 = cyc; budget = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      budget++;
      if (mem_rd_en) begin
        if (rd_cnt < 8) addr_log[rd_cnt] = mem_addr;
        rd_cnt++;
      end
      if (err) begin r_nerr++; r_err_off = cyc - t0; end
      if (out_valid) begin
        r_ov_cnt++;
        if (r_lat < 0) r_lat = cyc - t0;
      end
      if (abort_k > 0 && m_phase == P_RUN && m_k == abort_k) begin
        #2 rst_n = 1'b0;
        start = 1'b0; hash_vld = 1'b0;
        #1;
        chk("abort_ctrl_zero", {busy, mem_rd_en, hash_clr, hash_pix_vld, out_valid, err}, 0);
        chk("abort_data_zero", {mem_addr, hash_pix, hash_row, hash_col, perf_cycles}, 0);
        chk("abort_hash_zero", out_hash, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        done = 1;
      end else if (m_phase == P_IDLE) begin
        start = 1'b0; hash_vld = 1'b0;
        done = 1;
      end else if (budget > 400) begin
        n_chk++; n_fail++;
        $display("FAIL txn_timeout: transaction still busy after %0d cycles, required done", budget);
        start = 1'b0;
        done = 1;
      end else begin
        drive_cycle();
        if (m_phase == P_OUT) out_cycles++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, mem_rd_en, hash_clr, hash_pix_vld, out_valid, err}, 0);
    chk("reset_hash", out_hash, 0);
    chk("reset_perf", perf_cycles, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Base 0, zero-wait datapath answering in the drain cycle.
    run_txn(10'd0, 0, 0, 64'h0123456789ABCDEF, 0);
    chk("s1_latency", r_lat, 75);
    chk("s1_reads", rd_cnt, 72);
    chk("s1_out_hash", out_hash, 64'h0123456789ABCDEF);
    chk("s1_no_err", r_nerr, 0);
`ifdef DHASH_CTRL_PERF_EN
    chk("s1_perf", perf_cycles, 75);
`else
    chk("s1_perf", perf_cycles, 0);
`endif

    // Address wrap at the top of the RAM.
    run_txn(10'd1020, 3, 1, {$urandom, $urandom}, 0);
    chk("s2_addr0", addr_log[0], 1020);
    chk("s2_addr3", addr_log[3], 1023);
    chk("s2_addr4", addr_log[4], 0);
    chk("s2_reads", rd_cnt, 72);
    chk("s2_latency", r_lat, 78);
    chk("s2_no_err", r_nerr, 0);

    // Datapath never answers.
    run_txn(AW'($urandom), NEVER, 1, {$urandom, $urandom}, 0);
    chk("s3_err_count", r_nerr, 1);
    chk("s3_err_offset", r_err_off, 90);
    chk("s3_no_valid", r_ov_cnt, 0);

    // Downstream stalls 10 cycles while start is pulsed; then back-to-back.
    run_txn(AW'($urandom), 0, 2, {$urandom, $urandom}, 0);
    chk("s4_latency", r_lat, 75);
    chk("s4_valid_cycles", r_ov_cnt, 11);
    run_txn(AW'($urandom), 1, 1, {$urandom, $urandom}, 0);
    chk("s4_b2b_latency", r_lat, 76);

    // Reset during read 30, then a fresh full sequence.
    run_txn(AW'($urandom), 0, 1, {$urandom, $urandom}, 32);
    chk("s5_reads_before_abort", rd_cnt, 31);
    @(negedge clk);
    run_txn(AW'($urandom), 2, 1, {$urandom, $urandom}, 0);
    chk("s5_reads_after_abort", rd_cnt, 72);
    chk("s5_no_err", r_nerr, 0);

    // Randomised transactions, response delays on both sides of the timeout.
    for (int t = 0; t < 8; t++) begin
      run_txn(AW'($urandom), int'($urandom_range(18)), 1, {$urandom, $urandom}, 0);
      chk("rand_reads", rd_cnt, 72);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
